// File: rtl/iterative_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit covering the eight RV M-extension ops.
// Optional MULDIV_EARLY_OUT_EN: zero-operand / divide-by-zero / overflow ops skip CALC.
module iterative_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t            state, state_next;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_q, neg_r, special_q;
    logic [XLEN-1:0]   special_val_q;
    logic              accept;

    // Operand conditioning at accept
    logic              a_neg, b_neg, div_zero, div_ovf, special_now;
    logic [XLEN-1:0]   a_mag, b_mag, special_val_now;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        a_neg = op_a[XLEN-1] && (func3 == OP_MULH || func3 == OP_MULHSU ||
                                 func3 == OP_DIV  || func3 == OP_REM);
        b_neg = op_b[XLEN-1] && (func3 == OP_MULH || func3 == OP_DIV || func3 == OP_REM);
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
        div_zero = func3[2] && (op_b == '0);
        div_ovf  = func3[2] && !func3[0] && (op_a == MIN_NEG) && (op_b == '1);
        special_val_now = '0;
        if (div_zero)
            special_val_now = func3[1] ? op_a : '1;
        else if (div_ovf)
            special_val_now = func3[1] ? '0 : op_a;
`ifdef MULDIV_EARLY_OUT_EN
        special_now = div_zero || div_ovf || (!func3[2] && (op_a == '0 || op_b == '0));
`else
        special_now = div_zero || div_ovf;
`endif
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo, rem, final_val;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[2]) begin
            if (!div_diff[XLEN])
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_q ? -acc_next : acc_next;
        quo      = acc_next[XLEN-1:0];
        rem      = acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        final_val = acc_next[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_val = neg_q ? -quo : quo;
            default:                       final_val = neg_r ? -rem : rem;
        endcase
        if (special_q)
            final_val = special_val_q;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (start) begin
                    accept = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    state_next = special_now ? S_DONE : S_CALC;
`else
                    state_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (cnt == LAST_ITER) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            accept     = 1'b0;
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            op_q          <= OP_MUL;
            cnt           <= '0;
            acc           <= '0;
            opnd          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            result        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q          <= op_t'(func3);
                cnt           <= '0;
                neg_q         <= a_neg ^ b_neg;
                neg_r         <= a_neg;
                special_q     <= special_now;
                special_val_q <= special_val_now;
                // Divide iterates on the dividend, multiply shifts out the multiplier
                if (func3[2]) begin
                    acc  <= {{XLEN{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{XLEN{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (special_now)
                    result <= special_val_now;
`endif
            end else if (busy && !flush) begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST_ITER)
                    result <= final_val;
            end
        end
    end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Directed bench for iterative_muldiv_unit: vector table plus flush/reset/back-to-back sequences.
module tb_iterative_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk, rst, start, flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a, op_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    iterative_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .func3(func3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        bit              special;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] f3, input logic [XLEN-1:0] a, b, exp, input bit sp);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.special = sp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Called at the falling edge of a cycle; counts cycles until done (bounded)
    task automatic wait_done(input int first, output int lat, output bit busy_ok);
        lat = first;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // Issues start in the current cycle; returns at the falling edge of the done cycle
    task automatic do_op(input string name, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, b, exp, input bit sp);
        int lat;
        bit busy_ok;
        int exp_lat;
        start = 1'b1; func3 = f3; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, busy_ok);
        exp_lat = (EARLY && sp) ? 1 : LAT;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, result, exp);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        if (exp_lat > 1)
            check({name, "_busy_during_calc"}, {31'b0, busy_ok}, 32'd1);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check({name, "_no_done"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int lat;
        bit busy_ok;

        add(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0); // MUL
        add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0); // MULH
        add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU
        add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); // MULHSU
        add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0); // DIV
        add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0); // REM
        add(3'b101, 32'd100,       32'd7,         32'd14,        1'b0); // DIVU
        add(3'b111, 32'd100,       32'd7,         32'd2,         1'b0); // REMU
        add(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1); // DIVU /0
        add(3'b110, 32'd5,         32'd0,         32'd5,         1'b1); // REM /0
        add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); // DIV ovf
        add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1); // REM ovf
        add(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0); // MULH -1*2
        add(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); // MUL
        add(3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0); // MULHU
        add(3'b000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1); // MUL by 0
        add(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0); // DIV 7/-2
        add(3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0); // REM 7/-2
        add(3'b101, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 1'b0); // DIVU
        add(3'b111, 32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0); // REMU
        add(3'b100, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1'b1); // DIV -8/0
        add(3'b111, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1'b1); // REMU /0
        add(3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0); // DIV min/1

        rst = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].special);
            @(negedge clk);
        end
        check("idle_done_low", {31'b0, done}, 32'd0);

        // Back-to-back: second start issued in the done cycle of the first
        do_op("b2b_first",  3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        do_op("b2b_second", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);

        // start while busy must be ignored
        start = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; func3 = 3'b000; op_a = 32'd7; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, busy_ok);
        check("ignore_start_latency", 32'(lat), 32'(LAT));
        check("ignore_start_result", result, 32'd14);
        @(negedge clk);

        // flush at cycle 10: no done, result holds the previous value
        start = 1'b1; func3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", {31'b0, busy}, 32'd0);
        watch_no_done("flush_calc", 40);
        check("flush_result_held", result, 32'd14);

        // start and flush together in the done cycle: flush wins
        do_op("pre_flush_done", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        start = 1'b1; flush = 1'b1; func3 = 3'b000; op_a = 32'd7; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'd0);
        watch_no_done("flush_start", 40);
        check("flush_start_result", result, 32'd2);

        // reset in cycle 12 of a running op
        start = 1'b1; func3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("result_held_in_calc", result, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midreset_busy",   {31'b0, busy}, 32'd0);
        check("midreset_done",   {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        do_op("post_reset", 3'b011, 32'h8000_0000, 32'd4, 32'd2, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
